// File: rtl/led7seg_scan_ctrl.sv
// led7seg_scan_ctrl: time-multiplexed scan controller for common-anode 7-segment displays
// Walks one shared BCD-to-7-segment decoder across N_DIGITS digits, one active-low anode at a time,
// with GUARD_CYC dark cycles between digits. New digit data is double-buffered and only takes
// effect at frame boundaries (or immediately when scanning starts from idle).
// Ports:
//   clk       system clock, rising edge
//   rst_n     asynchronous active-low reset
//   en        scan enable; 0 blanks the display and abandons the frame
//   load      single-cycle strobe capturing data_in/dp_in into the pending buffer
//   data_in   BCD word, nibble i is digit i (nibble 0 rightmost)
//   dp_in     decimal-point request per digit, active-high
//   bcd       code of the digit being shown, to the decoder input
//   dp_n      decimal point, active-low
//   an        anode enables, active-low, at most one bit low
//   digit_idx index of the current or next digit
// Macro LED7SEG_BLANK_EN: when defined, leading-zero blanking keeps digit i>0 dark if all
// active nibbles and dp bits from i upward are zero.
module led7seg_scan_ctrl #(
    parameter int N_DIGITS  = 4,
    parameter int CLK_DIV   = 50000,
    parameter int GUARD_CYC = 2
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        en,
    input  logic                        load,
    input  logic [4*N_DIGITS-1:0]       data_in,
    input  logic [N_DIGITS-1:0]         dp_in,
    output logic [3:0]                  bcd,
    output logic                        dp_n,
    output logic [N_DIGITS-1:0]         an,
    output logic [$clog2(N_DIGITS)-1:0] digit_idx
);
    localparam int IW   = $clog2(N_DIGITS);
    localparam int CMAX = (CLK_DIV > GUARD_CYC) ? CLK_DIV : GUARD_CYC;
    localparam int CW   = $clog2(CMAX);

    typedef enum logic [1:0] {IDLE, SHOW, GUARD} state_t;

    state_t                r_state, w_state;
    logic [CW-1:0]         r_cnt, w_cnt;
    logic [IW-1:0]         r_idx, w_idx;
    logic [4*N_DIGITS-1:0] r_act_data, r_pend_data, w_act_data;
    logic [N_DIGITS-1:0]   r_act_dp, r_pend_dp, w_act_dp;
    logic [N_DIGITS-1:0]   r_an, w_an, w_blank;
    logic                  r_pend_valid, w_commit;
    logic [3:0]            r_bcd;
    logic                  r_dp_n;
    logic                  w_show_end, w_guard_end, w_last;

    assign w_show_end  = r_cnt == CW'(CLK_DIV - 1);
    assign w_guard_end = r_cnt == CW'(GUARD_CYC - 1);
    assign w_last      = r_idx == IW'(N_DIGITS - 1);

    // Next-state logic; outputs are registered from the next state so the
    // anode pattern changes on the same edge as the state it belongs to.
    always_comb begin
        w_state  = r_state;
        w_cnt    = r_cnt;
        w_idx    = r_idx;
        w_commit = 1'b0;
        if (!en) begin
            w_state = IDLE;
            w_cnt   = '0;
            w_idx   = '0;
        end else if (r_state == IDLE) begin
            w_state  = SHOW;
            w_cnt    = '0;
            w_idx    = '0;
            w_commit = 1'b1;
        end else if (r_state == SHOW) begin
            w_state = w_show_end ? GUARD : SHOW;
            w_cnt   = w_show_end ? '0 : r_cnt + 1'b1;
        end else begin
            w_state  = w_guard_end ? SHOW : GUARD;
            w_cnt    = w_guard_end ? '0 : r_cnt + 1'b1;
            w_idx    = w_guard_end ? (w_last ? '0 : r_idx + 1'b1) : r_idx;
            w_commit = w_guard_end && w_last;
        end
    end

    // A load on the commit edge bypasses the pending buffer.
    assign w_act_data = (load && w_commit) ? data_in :
                        (w_commit && r_pend_valid) ? r_pend_data : r_act_data;
    assign w_act_dp   = (load && w_commit) ? dp_in :
                        (w_commit && r_pend_valid) ? r_pend_dp : r_act_dp;

`ifdef LED7SEG_BLANK_EN
    logic w_zero;
    always_comb begin
        w_zero  = 1'b1;
        w_blank = '0;
        for (int i = N_DIGITS - 1; i > 0; i--) begin
            w_zero     = w_zero && w_act_data[4*i +: 4] == 4'd0 && !w_act_dp[i];
            w_blank[i] = w_zero;
        end
    end
`else
    assign w_blank = '0;
`endif

    assign w_an = (w_state == SHOW) ? (~(N_DIGITS'(1) << w_idx) | w_blank) : '1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_idx        <= '0;
            r_act_data   <= '0;
            r_act_dp     <= '0;
            r_pend_data  <= '0;
            r_pend_dp    <= '0;
            r_pend_valid <= 1'b0;
            r_an         <= '1;
            r_bcd        <= 4'd0;
            r_dp_n       <= 1'b1;
        end else begin
            r_state    <= w_state;
            r_cnt      <= w_cnt;
            r_idx      <= w_idx;
            r_act_data <= w_act_data;
            r_act_dp   <= w_act_dp;
            if (load && !w_commit) begin
                r_pend_data  <= data_in;
                r_pend_dp    <= dp_in;
                r_pend_valid <= 1'b1;
            end else if (w_commit) begin
                r_pend_valid <= 1'b0;
            end
            r_an <= w_an;
            // bcd and dp_n hold their last values outside SHOW
            if (w_state == SHOW) begin
                r_bcd  <= w_act_data[4*w_idx +: 4];
                r_dp_n <= ~w_act_dp[w_idx];
            end
        end
    end

    assign an        = r_an;
    assign bcd       = r_bcd;
    assign dp_n      = r_dp_n;
    assign digit_idx = r_idx;
endmodule
